// File: rtl/mont_domain_converter_if.sv
// Coefficient stream between memory/NTT datapath and the Montgomery domain converter.
// Valid/ready on both sides; mode travels with each input beat.
interface mont_domain_converter_if;
   logic        mode;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mont_domain_converter.sv
// Normal <-> Montgomery domain converter: R^2 mod q precomputed on init,
// then a 3-stage valid/ready Montgomery reduction pipeline.
module mont_domain_converter #(
   parameter int unsigned PARAM_RLOG = 18
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            modulus,
   input  logic [PARAM_RLOG-1:0]  param_MinQinvModR,
   input  logic                   init,
   output logic                   init_done,
   mont_domain_converter_if.slave stream
);

   localparam int unsigned Q_W    = 16;
   localparam int unsigned T_W    = Q_W + 1;
   localparam int unsigned A_W    = 2 * Q_W;
   localparam int unsigned PROD_W = PARAM_RLOG + Q_W;
   localparam int unsigned AP_W   = ((PROD_W > A_W) ? PROD_W : A_W) + 1;
   localparam int unsigned STEPS  = 2 * PARAM_RLOG;
   localparam int unsigned CNT_W  = $clog2(STEPS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RUN = 2'd2} state_t;

   state_t               state;
   logic [Q_W-1:0]       r;
   logic [Q_W-1:0]       r2;
   logic [CNT_W-1:0]     cnt;

   logic [T_W-1:0]       r_dbl;
   logic [T_W-1:0]       r_sub;
   logic [Q_W-1:0]       r_next;

   // One modular doubling step of the R^2 mod q precompute
   always_comb begin
      r_dbl  = {r, 1'b0};
      r_sub  = r_dbl - {1'b0, modulus};
      r_next = (r_dbl >= {1'b0, modulus}) ? Q_W'(r_sub) : Q_W'(r_dbl);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r         <= '0;
         r2        <= '0;
         cnt       <= '0;
         init_done <= 1'b0;
      end else if (init) begin
         state     <= CALC;
         r         <= Q_W'(1);
         cnt       <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               r <= r_next;
               if (cnt == CNT_W'(STEPS - 1)) begin
                  r2        <= r_next;
                  state     <= RUN;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN:     state <= RUN;
            IDLE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic                  en;
   logic                  in_ready_c;
   logic                  accept;
   logic [Q_W-1:0]        mult;
   logic [A_W-1:0]        a_c;
   logic [PARAM_RLOG-1:0] u_c;
   logic [AP_W-1:0]       ap_c;
   logic [T_W-1:0]        t_c;
   logic [T_W-1:0]        t_red;

   logic                  v1;
   logic                  v2;
   logic [A_W-1:0]        a1;
   logic [A_W-1:0]        a2;
   logic [PARAM_RLOG-1:0] u2;

   assign en              = !stream.out_valid || stream.out_ready;
   assign in_ready_c      = (state == RUN) && en;
   assign stream.in_ready = in_ready_c;
   assign accept          = stream.in_valid && in_ready_c;

   // Stage datapaths; ap's low PARAM_RLOG bits are zero by construction of u
   always_comb begin
      mult  = stream.mode ? Q_W'(1) : r2;
      a_c   = A_W'(stream.in_data) * A_W'(mult);
      u_c   = PARAM_RLOG'(a1[PARAM_RLOG-1:0] * param_MinQinvModR);
      ap_c  = AP_W'(a2) + AP_W'(u2) * AP_W'(modulus);
      t_c   = T_W'(ap_c >> PARAM_RLOG);
      t_red = (t_c >= T_W'(modulus)) ? (t_c - T_W'(modulus)) : t_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1               <= 1'b0;
         v2               <= 1'b0;
         a1               <= '0;
         a2               <= '0;
         u2               <= '0;
         stream.out_valid <= 1'b0;
         stream.out_data  <= '0;
      end else if (init) begin
         v1               <= 1'b0;
         v2               <= 1'b0;
         stream.out_valid <= 1'b0;
      end else if (en) begin
         v1               <= accept;
         a1               <= a_c;
         v2               <= v1;
         a2               <= a1;
         u2               <= u_c;
         stream.out_valid <= v2;
         if (v2) stream.out_data <= Q_W'(t_red);
      end
   end

endmodule

// File: tb/tb_mont_domain_converter.sv
// Directed bench for mont_domain_converter with q=3329, R=2^18.
// Expected values are hand-computed modular results.
module tb_mont_domain_converter;

   localparam int unsigned RLOG = 18;
   localparam logic [15:0]     Q    = 16'd3329;
   localparam logic [RLOG-1:0] QINV = 18'd199935;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [15:0]     modulus;
   logic [RLOG-1:0] qinv;
   logic            init;
   logic            init_done;

   mont_domain_converter_if bus();

   mont_domain_converter #(.PARAM_RLOG(RLOG)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .modulus           (modulus),
      .param_MinQinvModR (qinv),
      .init              (init),
      .init_done         (init_done),
      .stream            (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] outq[$];
   logic        acc_flag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one clock: record handshakes at the edge, verify stalled outputs hold
   task automatic step();
      logic        stall;
      logic [15:0] hold_d;
      #2;
      acc_flag = bus.in_valid && bus.in_ready;
      stall    = bus.out_valid && !bus.out_ready && !init && rst_n;
      hold_d   = bus.out_data;
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
      @(posedge clk);
      #1;
      if (stall && rst_n) begin
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_data", 32'(bus.out_data), 32'(hold_d));
      end
   endtask

   logic        bp_mode[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [15:0] bp_in[8]   = '{16'd1, 16'd0, 16'd3328, 16'd2482, 16'd847, 16'd2, 16'd1635, 16'd1000};
   logic [15:0] bp_exp[8]  = '{16'd2482, 16'd0, 16'd847, 16'd1, 16'd3328, 16'd1635, 16'd2, 16'd1895};

   initial begin
      logic [15:0] x[6];
      logic [15:0] y[6];
      int          idx;
      int          bad;

      modulus       = Q;
      qinv          = QINV;
      init          = 1'b0;
      bus.mode      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // R^2 mod q precompute: RUN reached 36 cycles after entering CALC
      init = 1'b1;
      step();
      init = 1'b0;
      repeat (35) step();
      chk("calc_done_early", 32'(init_done), 32'd0);
      chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("calc_done", 32'(init_done), 32'd1);
      chk("calc_r2", 32'(dut.r2), 32'd1674);
      chk("run_in_ready", 32'(bus.in_ready), 32'd1);

      // to-Montgomery back-to-back, 3-cycle latency
      bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd1;
      step();
      chk("lat_accept", 32'(acc_flag), 32'd1);
      bus.in_data = 16'd0;
      step();
      chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      bus.in_data = 16'd3328;
      step();
      bus.in_valid = 1'b0;
      chk("tm_v0", 32'(bus.out_valid), 32'd1);
      chk("tm_d0", 32'(bus.out_data), 32'd2482);
      step();
      chk("tm_v1", 32'(bus.out_valid), 32'd1);
      chk("tm_d1", 32'(bus.out_data), 32'd0);
      step();
      chk("tm_v2", 32'(bus.out_valid), 32'd1);
      chk("tm_d2", 32'(bus.out_data), 32'd847);
      step();
      chk("tm_drain_valid", 32'(bus.out_valid), 32'd0);
      chk("tm_drain_hold", 32'(bus.out_data), 32'd847);

      // from-Montgomery
      bus.mode = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'd2482;
      step();
      bus.in_data = 16'd847;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("fm_d0", 32'(bus.out_data), 32'd1);
      step();
      chk("fm_d1", 32'(bus.out_data), 32'd3328);
      step();

      // Random round trip: to-Montgomery then from-Montgomery returns x
      foreach (x[i]) x[i] = 16'($urandom_range(0, 3328));
      outq.delete();
      bus.mode = 1'b0;
      foreach (x[i]) begin
         bus.in_valid = 1'b1; bus.in_data = x[i];
         step();
      end
      bus.in_valid = 1'b0;
      repeat (4) step();
      chk("rt1_count", 32'(outq.size()), 32'd6);
      foreach (y[i]) begin
         y[i] = outq[i];
         chk("rt1_range", 32'(y[i] < Q), 32'd1);
      end
      outq.delete();
      bus.mode = 1'b1;
      foreach (y[i]) begin
         bus.in_valid = 1'b1; bus.in_data = y[i];
         step();
      end
      bus.in_valid = 1'b0;
      repeat (4) step();
      chk("rt2_count", 32'(outq.size()), 32'd6);
      foreach (x[i]) chk("rt2_data", 32'(outq[i]), 32'(x[i]));

      // Backpressure with mixed modes; out_ready low for 5 cycles then random
      outq.delete();
      idx = 0;
      for (int cyc = 0; cyc < 300 && outq.size() < 8; cyc++) begin
         bus.in_valid = (idx < 8);
         if (idx < 8) begin
            bus.mode    = bp_mode[idx];
            bus.in_data = bp_in[idx];
         end
         bus.out_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
         step();
         if (acc_flag) idx++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_count", 32'(outq.size()), 32'd8);
      for (int i = 0; i < 8; i++) chk("bp_data", 32'(outq[i]), 32'(bp_exp[i]));
      repeat (4) step();

      // init with three beats in flight
      bus.out_ready = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = 16'd5; step();
      bus.in_data = 16'd6; step();
      bus.in_data = 16'd7; step();
      bus.in_valid = 1'b0;
      step();
      outq.delete();
      init = 1'b1;
      step();
      init = 1'b0;
      chk("reinit_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reinit_done", 32'(init_done), 32'd0);
      bus.out_ready = 1'b1;
      bad = 0;
      repeat (35) begin
         step();
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      end
      chk("reinit_quiet", 32'(bad), 32'd0);
      chk("reinit_done_early", 32'(init_done), 32'd0);
      step();
      chk("reinit_done_late", 32'(init_done), 32'd1);
      chk("reinit_flushed", 32'(outq.size()), 32'd0);
      bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd1000;
      step();
      bus.in_valid = 1'b0;
      repeat (3) step();
      chk("reinit_conv_count", 32'(outq.size()), 32'd1);
      chk("reinit_conv_data", 32'(outq[0]), 32'd1895);

      // Asynchronous reset mid-stream
      bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd5;
      repeat (3) step();
      chk("pre_rst_data", 32'(bus.out_data), 32'd2423);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_data", 32'(bus.out_data), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("arst_init_done", 32'(init_done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      outq.delete();
      repeat (5) step();
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("post_rst_init_done", 32'(init_done), 32'd0);
      chk("post_rst_no_out", 32'(outq.size()), 32'd0);
      bus.in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
